id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register with load-use hazard detection and bubble insertion.
//  Sits directly downstream of the decode control unit and captures its RegWrite, ALUSrc,
//  MemRead, MemWrite and Mem2Reg outputs, plus the decoded operands, for the EX stage.
//  Drives stall_o back to PC/IF-ID. Converts EX-stage branch flushes and load-use
//  hazards into bubbles.
// PARAMETERS
//  XLEN    32  datapath width (pc, operands, immediate)
//  REG_AW  5   register index width
//  CNT_W   32  bubble performance-counter width
// PORTS
//  clk            in   1       rising-edge clock; the only clock
//  rst_n          in   1       reset, asynchronous assert, active-low
//  hold_i         in   1       global freeze (memory stall); stage keeps contents
//  flush_i        in   1       EX branch/jump taken; discard instruction entering EX
//  id_valid_i     in   1       ID holds a real instruction
//  id_regwrite_i  in   1       decode control: RegWrite
//  id_alusrc_i    in   1       decode control: ALUSrc
//  id_memread_i   in   1       decode control: MemRead
//  id_memwrite_i  in   1       decode control: MemWrite
//  id_mem2reg_i   in   1       decode control: Mem2Reg
//  id_branch_i    in   1       SB-type instruction
//  id_jump_i      in   1       UJ-type instruction
//  id_rs1_i       in   REG_AW  source register 1 index
//  id_rs2_i       in   REG_AW  source register 2 index
//  id_rd_i        in   REG_AW  destination register index
//  id_pc_i        in   XLEN    instruction PC
//  id_rd1_i       in   XLEN    register-file read data 1
//  id_rd2_i       in   XLEN    register-file read data 2
//  id_imm_i       in   XLEN    sign-extended immediate
//  ex_*_o         out  (same)  registered copies of every id_*_i above (ex_valid_o, ex_regwrite_o, ...)
//  stall_o        out  1       combinational; hold PC and IF/ID this cycle
//  bubble_cnt_o   out  CNT_W   bubbles inserted since reset, saturating
// BEHAVIOUR
//  Reset: all ex_* outputs 0 (a bubble), bubble_cnt_o 0, FSM in RUN, stall_o 0.
//  Latency: 1 cycle from ID inputs to ex_* outputs.
//  Hazard (combinational): haz = ex_valid_o & ex_memread_o & (ex_rd_o != 0) &
//    ((ex_rd_o == id_rs1_i) | (ex_rd_o == id_rs2_i)) & id_valid_i.
//    stall_o = haz & ~flush_i & ~hold_i.
//  Bubble: ex_valid, regwrite, memread, memwrite, mem2reg, branch and jump are 0;
//    all other ex_* fields are 0 as well.
//  Per-edge priority, highest first:
//    1. hold_i=1: every ex_* register is unchanged. If flush_i=1, go to FLUSH_PEND.
//    2. flush_i=1, or FSM in FLUSH_PEND: load a bubble and return to RUN.
//    3. haz=1: load a bubble. ID is re-presented on the next cycle because of stall_o.
//    4. Otherwise: capture ID. If id_valid_i=0, load a bubble.
//  FSM states: RUN, FLUSH_PEND.
//    RUN -> FLUSH_PEND on hold_i & flush_i.
//    FLUSH_PEND -> RUN on the first edge where hold_i=0; a bubble is loaded on that edge.
//  x0 rule: when capturing with id_rd_i == 0, ex_regwrite_o is forced to 0.
//  bubble_cnt_o: +1 on each edge that loads a bubble via rule 2 or rule 3.
//    Saturates at all-ones and does not wrap. Unchanged during hold.
//  A 2-cycle load-use chain raises stall_o for exactly 1 cycle, because the bubble clears haz.
//  rst_n low mid-operation: outputs clear immediately (asynchronous) and the pending flush is dropped.
// STRUCTURE
//  Shared package: ctrl_t packed struct {regwrite, alusrc, memread, memwrite, mem2reg,
//    branch, jump}; localparam CTRL_BUBBLE = '0; FSM state enum.
//  Sub-module: hazard_detect (purely combinational, produces haz). All registers stay in id_ex_stage.
// TESTING
//  1. Reset: rst_n=0 asynchronously mid-cycle -> all ex_* = 0 immediately, bubble_cnt_o = 0.
//  2. lw x5 (id_memread=1, rd=5) then add rs1=5 -> stall_o=1 for 1 cycle; ex_valid_o=0 next;
//     the add reaches EX one cycle later; bubble_cnt_o=1.
//  3. lw with rd=0, then consumer rs1=0 -> stall_o stays 0; lw's ex_regwrite_o=0.
//  4. flush_i=1 with an instruction (pc=0x40) in ID -> ex_valid_o=0 next cycle; a coincident
//     haz does not raise stall_o.
//  5. hold_i=1 for 3 cycles with a pulse on flush_i in cycle 1 -> ex_* frozen for 3 cycles,
//     then a bubble on release; counter +1.
//  6. Force bubble_cnt_o to all-ones, then trigger a hazard -> bubble_cnt_o stays all-ones.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared types for the ID/EX pipeline register: control bundle, bubble value, FSM states.
package id_ex_stage_pkg;

  // Decode control fields carried from ID into EX.
  typedef struct packed {
    logic regwrite;
    logic alusrc;
    logic memread;
    logic memwrite;
    logic mem2reg;
    logic branch;
    logic jump;
  } ctrl_t;

  // Control value of an inserted bubble: no side effects in later stages.
  localparam ctrl_t CTRL_BUBBLE = '0;

  // RUN: normal flow. FLUSH_PEND: a flush arrived while frozen; bubble on release.
  typedef enum logic [0:0] {
    RUN        = 1'b0,
    FLUSH_PEND = 1'b1
  } state_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: the instruction in EX is a load whose destination
// is read by the instruction currently in ID.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  output logic              haz
);

  // x0 never carries a dependency, so rd == 0 cannot cause a stall.
  always_comb begin
    haz = ex_valid && ex_memread && (ex_rd != '0) &&
          ((ex_rd == id_rs1) || (ex_rd == id_rs2)) && id_valid;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall generation, flush/hazard bubble
// insertion, flush-during-hold memory and a saturating bubble counter.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic              id_regwrite_i,
  input  logic              id_alusrc_i,
  input  logic              id_memread_i,
  input  logic              id_memwrite_i,
  input  logic              id_mem2reg_i,
  input  logic              id_branch_i,
  input  logic              id_jump_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [XLEN-1:0]   id_rd1_i,
  input  logic [XLEN-1:0]   id_rd2_i,
  input  logic [XLEN-1:0]   id_imm_i,
  output logic              ex_valid_o,
  output logic              ex_regwrite_o,
  output logic              ex_alusrc_o,
  output logic              ex_memread_o,
  output logic              ex_memwrite_o,
  output logic              ex_mem2reg_o,
  output logic              ex_branch_o,
  output logic              ex_jump_o,
  output logic [REG_AW-1:0] ex_rs1_o,
  output logic [REG_AW-1:0] ex_rs2_o,
  output logic [REG_AW-1:0] ex_rd_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_rd1_o,
  output logic [XLEN-1:0]   ex_rd2_o,
  output logic [XLEN-1:0]   ex_imm_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  state_t            state_r, state_nxt_s;
  ctrl_t             ex_ctrl_r, id_ctrl_s;
  logic              ex_valid_r;
  logic [REG_AW-1:0] ex_rs1_r, ex_rs2_r, ex_rd_r;
  logic [XLEN-1:0]   ex_pc_r, ex_rd1_r, ex_rd2_r, ex_imm_r;
  logic [CNT_W-1:0]  bubble_cnt_r;
  logic              haz_s, flush_evt_s, haz_evt_s, count_evt_s;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
    .ex_valid   (ex_valid_r),
    .ex_memread (ex_ctrl_r.memread),
    .ex_rd      (ex_rd_r),
    .id_valid   (id_valid_i),
    .id_rs1     (id_rs1_i),
    .id_rs2     (id_rs2_i),
    .haz        (haz_s)
  );

  // A flush or a hold already keeps the ID instruction from advancing, so no stall then.
  assign stall_o = haz_s && !flush_i && !hold_i;

  // Classify this edge: flush bubble (incl. one deferred by hold) beats hazard bubble.
  always_comb begin
    flush_evt_s = !hold_i && (flush_i || (state_r == FLUSH_PEND));
    haz_evt_s   = !hold_i && !flush_evt_s && haz_s;
    count_evt_s = flush_evt_s || haz_evt_s;
  end

  // Decoded control as captured; writes to x0 are suppressed here.
  always_comb begin
    id_ctrl_s          = CTRL_BUBBLE;
    id_ctrl_s.regwrite = id_regwrite_i && (id_rd_i != '0);
    id_ctrl_s.alusrc   = id_alusrc_i;
    id_ctrl_s.memread  = id_memread_i;
    id_ctrl_s.memwrite = id_memwrite_i;
    id_ctrl_s.mem2reg  = id_mem2reg_i;
    id_ctrl_s.branch   = id_branch_i;
    id_ctrl_s.jump     = id_jump_i;
  end

  // Remember a flush that arrives while frozen until the freeze lifts.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      RUN: begin
        if (hold_i && flush_i) state_nxt_s = FLUSH_PEND;
        else                   state_nxt_s = RUN;
      end
      FLUSH_PEND: begin
        if (!hold_i) state_nxt_s = RUN;
        else         state_nxt_s = FLUSH_PEND;
      end
      default: state_nxt_s = RUN;
    endcase
  end

  // FSM state register; reset drops any pending flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= RUN;
    else        state_r <= state_nxt_s;
  end

  // Pipeline register: hold freezes, events and invalid ID load a bubble, else capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_r <= 1'b0;
      ex_ctrl_r  <= CTRL_BUBBLE;
      ex_rs1_r   <= '0;
      ex_rs2_r   <= '0;
      ex_rd_r    <= '0;
      ex_pc_r    <= '0;
      ex_rd1_r   <= '0;
      ex_rd2_r   <= '0;
      ex_imm_r   <= '0;
    end else if (hold_i) begin
      ex_valid_r <= ex_valid_r;
    end else if (count_evt_s || !id_valid_i) begin
      ex_valid_r <= 1'b0;
      ex_ctrl_r  <= CTRL_BUBBLE;
      ex_rs1_r   <= '0;
      ex_rs2_r   <= '0;
      ex_rd_r    <= '0;
      ex_pc_r    <= '0;
      ex_rd1_r   <= '0;
      ex_rd2_r   <= '0;
      ex_imm_r   <= '0;
    end else begin
      ex_valid_r <= 1'b1;
      ex_ctrl_r  <= id_ctrl_s;
      ex_rs1_r   <= id_rs1_i;
      ex_rs2_r   <= id_rs2_i;
      ex_rd_r    <= id_rd_i;
      ex_pc_r    <= id_pc_i;
      ex_rd1_r   <= id_rd1_i;
      ex_rd2_r   <= id_rd2_i;
      ex_imm_r   <= id_imm_i;
    end
  end

  // Saturating count of flush/hazard bubbles; invalid-ID bubbles are not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_r <= '0;
    end else if (count_evt_s && !(&bubble_cnt_r)) begin
      bubble_cnt_r <= bubble_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign ex_valid_o    = ex_valid_r;
  assign ex_regwrite_o = ex_ctrl_r.regwrite;
  assign ex_alusrc_o   = ex_ctrl_r.alusrc;
  assign ex_memread_o  = ex_ctrl_r.memread;
  assign ex_memwrite_o = ex_ctrl_r.memwrite;
  assign ex_mem2reg_o  = ex_ctrl_r.mem2reg;
  assign ex_branch_o   = ex_ctrl_r.branch;
  assign ex_jump_o     = ex_ctrl_r.jump;
  assign ex_rs1_o      = ex_rs1_r;
  assign ex_rs2_o      = ex_rs2_r;
  assign ex_rd_o       = ex_rd_r;
  assign ex_pc_o       = ex_pc_r;
  assign ex_rd1_o      = ex_rd1_r;
  assign ex_rd2_o      = ex_rd2_r;
  assign ex_imm_o      = ex_imm_r;
  assign bubble_cnt_o  = bubble_cnt_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use stall, x0 rule, flush,
// hold with deferred flush, and counter saturation (narrow counter instance).
module tb_id_ex_stage;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  logic rst_n, hold_i, flush_i;
  logic id_valid_i, id_regwrite_i, id_alusrc_i, id_memread_i, id_memwrite_i;
  logic id_mem2reg_i, id_branch_i, id_jump_i;
  logic [REG_AW-1:0] id_rs1_i, id_rs2_i, id_rd_i;
  logic [XLEN-1:0]   id_pc_i, id_rd1_i, id_rd2_i, id_imm_i;
  logic ex_valid_o, ex_regwrite_o, ex_alusrc_o, ex_memread_o, ex_memwrite_o;
  logic ex_mem2reg_o, ex_branch_o, ex_jump_o, stall_o;
  logic [REG_AW-1:0] ex_rs1_o, ex_rs2_o, ex_rd_o;
  logic [XLEN-1:0]   ex_pc_o, ex_rd1_o, ex_rd2_o, ex_imm_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_regwrite_i(id_regwrite_i), .id_alusrc_i(id_alusrc_i),
    .id_memread_i(id_memread_i), .id_memwrite_i(id_memwrite_i), .id_mem2reg_i(id_mem2reg_i),
    .id_branch_i(id_branch_i), .id_jump_i(id_jump_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
    .id_pc_i(id_pc_i), .id_rd1_i(id_rd1_i), .id_rd2_i(id_rd2_i), .id_imm_i(id_imm_i),
    .ex_valid_o(ex_valid_o), .ex_regwrite_o(ex_regwrite_o), .ex_alusrc_o(ex_alusrc_o),
    .ex_memread_o(ex_memread_o), .ex_memwrite_o(ex_memwrite_o), .ex_mem2reg_o(ex_mem2reg_o),
    .ex_branch_o(ex_branch_o), .ex_jump_o(ex_jump_o),
    .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o),
    .ex_pc_o(ex_pc_o), .ex_rd1_o(ex_rd1_o), .ex_rd2_o(ex_rd2_o), .ex_imm_o(ex_imm_o),
    .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec = n_vec + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one ID instruction: {valid,regwrite,alusrc,memread,memwrite,mem2reg,branch,jump}.
  task automatic set_id(input logic [7:0] c, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] rd1,
                        input logic [31:0] rd2, input logic [31:0] imm);
    {id_valid_i, id_regwrite_i, id_alusrc_i, id_memread_i,
     id_memwrite_i, id_mem2reg_i, id_branch_i, id_jump_i} = c;
    id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
    id_pc_i = pc; id_rd1_i = rd1; id_rd2_i = rd2; id_imm_i = imm;
  endtask

  localparam logic [7:0] ALU  = 8'b1100_0000;
  localparam logic [7:0] LOAD = 8'b1111_0100;
  localparam logic [7:0] NOP  = 8'b0000_0000;

  initial begin
    rst_n = 1'b0; hold_i = 1'b0; flush_i = 1'b0;
    set_id(NOP, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0);

    // 1. reset state, then asynchronous reset mid-cycle
    #2;
    check("rst_valid", 32'(ex_valid_o), 32'h0);
    check("rst_cnt",   32'(bubble_cnt_o), 32'h0);
    check("rst_stall", 32'(stall_o), 32'h0);
    #10 rst_n = 1'b1;
    set_id(ALU, 5'd1, 5'd2, 5'd7, 32'h10, 32'h11, 32'h22, 32'h33);
    tick();
    check("cap_valid", 32'(ex_valid_o), 32'h1);
    check("cap_pc",    ex_pc_o, 32'h10);
    check("cap_rd",    32'(ex_rd_o), 32'h7);
    check("cap_rd2",   ex_rd2_o, 32'h22);
    check("cap_imm",   ex_imm_o, 32'h33);
    check("cap_rw",    32'(ex_regwrite_o), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(ex_valid_o), 32'h0);
    check("arst_pc",    ex_pc_o, 32'h0);
    check("arst_rw",    32'(ex_regwrite_o), 32'h0);
    #1 rst_n = 1'b1;

    // 2. lw x5 then add rs1=x5: one stall cycle, one bubble
    set_id(LOAD, 5'd2, 5'd0, 5'd5, 32'h20, 32'h0, 32'h0, 32'h8);
    #1 check("lw_nostall", 32'(stall_o), 32'h0);
    tick();
    check("lw_memread", 32'(ex_memread_o), 32'h1);
    check("lw_alusrc",  32'(ex_alusrc_o), 32'h1);
    set_id(ALU, 5'd5, 5'd6, 5'd9, 32'h24, 32'h1, 32'h2, 32'h0);
    #1 check("lu_stall", 32'(stall_o), 32'h1);
    tick();
    check("lu_bubble", 32'(ex_valid_o), 32'h0);
    check("lu_cnt",    32'(bubble_cnt_o), 32'h1);
    check("lu_stall_clr", 32'(stall_o), 32'h0);
    tick();
    check("lu_add_valid", 32'(ex_valid_o), 32'h1);
    check("lu_add_pc",    ex_pc_o, 32'h24);
    check("lu_add_rd",    32'(ex_rd_o), 32'h9);
    check("lu_cnt2",      32'(bubble_cnt_o), 32'h1);

    // 3. lw to x0: regwrite dropped, consumer of x0 does not stall
    set_id(LOAD, 5'd3, 5'd0, 5'd0, 32'h30, 32'h0, 32'h0, 32'h0);
    tick();
    check("x0_rw",      32'(ex_regwrite_o), 32'h0);
    check("x0_memread", 32'(ex_memread_o), 32'h1);
    set_id(ALU, 5'd0, 5'd1, 5'd4, 32'h34, 32'h0, 32'h0, 32'h0);
    #1 check("x0_nostall", 32'(stall_o), 32'h0);
    tick();
    check("x0_pc",  ex_pc_o, 32'h34);
    check("x0_cnt", 32'(bubble_cnt_o), 32'h1);

    // 4. flush with coincident hazard: no stall, bubble counted
    set_id(LOAD, 5'd1, 5'd0, 5'd6, 32'h3C, 32'h0, 32'h0, 32'h0);
    tick();
    set_id(ALU, 5'd6, 5'd0, 5'd8, 32'h40, 32'h0, 32'h0, 32'h0);
    flush_i = 1'b1;
    #1 check("fl_nostall", 32'(stall_o), 32'h0);
    tick();
    flush_i = 1'b0;
    check("fl_bubble", 32'(ex_valid_o), 32'h0);
    check("fl_pc",     ex_pc_o, 32'h0);
    check("fl_cnt",    32'(bubble_cnt_o), 32'h2);
    set_id(ALU, 5'd1, 5'd2, 5'd8, 32'h44, 32'h0, 32'h0, 32'h0);
    tick();
    check("fl_next_pc", ex_pc_o, 32'h44);

    // 5. hold 3 cycles with flush pulse in the first: frozen, then bubble on release
    set_id(ALU, 5'd1, 5'd2, 5'd10, 32'h48, 32'h0, 32'h0, 32'h0);
    hold_i = 1'b1; flush_i = 1'b1;
    #1 check("hd_nostall", 32'(stall_o), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      flush_i = 1'b0;
      check("hd_pc",    ex_pc_o, 32'h44);
      check("hd_valid", 32'(ex_valid_o), 32'h1);
      check("hd_cnt",   32'(bubble_cnt_o), 32'h2);
    end
    hold_i = 1'b0;
    tick();
    check("hd_rel_bubble", 32'(ex_valid_o), 32'h0);
    check("hd_rel_cnt",    32'(bubble_cnt_o), 32'h3);
    tick();
    check("hd_after_pc", ex_pc_o, 32'h48);
    check("hd_after_cnt", 32'(bubble_cnt_o), 32'h3);

    // invalid ID: bubble, not counted
    set_id(NOP, 5'd0, 5'd0, 5'd0, 32'h4C, 32'h0, 32'h0, 32'h0);
    tick();
    check("inv_valid", 32'(ex_valid_o), 32'h0);
    check("inv_cnt",   32'(bubble_cnt_o), 32'h3);

    // 6. drive counter to all-ones (12 flush bubbles), then a hazard must not wrap it
    flush_i = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    flush_i = 1'b0;
    check("sat_full", 32'(bubble_cnt_o), 32'hF);
    set_id(LOAD, 5'd1, 5'd0, 5'd5, 32'h50, 32'h0, 32'h0, 32'h0);
    tick();
    set_id(ALU, 5'd5, 5'd0, 5'd9, 32'h54, 32'h0, 32'h0, 32'h0);
    #1 check("sat_stall", 32'(stall_o), 32'h1);
    tick();
    check("sat_bubble", 32'(ex_valid_o), 32'h0);
    check("sat_hold",   32'(bubble_cnt_o), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
